// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV immediate generator (I/S/B/U/J) behind a
// valid/ready handshake with a 2-entry skid buffer and a sideband tag.
// Ports: clk, reset_n (async, active-low), flush (sync, highest priority);
//   upstream:   in_valid, in_ready, instr[31:7], imm_src[2:0], in_tag
//   downstream: out_valid, out_ready, imm_ext[XLEN-1:0], imm_err, out_tag
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:7]      instr,
    input  logic [2:0]       imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_ext,
    output logic             imm_err,
    output logic [TAG_W-1:0] out_tag
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $fatal(1, "imm_gen_pipe: TAG_W must be >= 1");
    end

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_TWO
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   main_imm_q, main_imm_d;
    logic              main_err_q, main_err_d;
    logic [TAG_W-1:0]  main_tag_q, main_tag_d;
    logic [XLEN-1:0]   skid_imm_q, skid_imm_d;
    logic              skid_err_q, skid_err_d;
    logic [TAG_W-1:0]  skid_tag_q, skid_tag_d;

    logic              main_valid;
    logic              skid_valid;
    logic              accept;
    logic              pop;
    logic              s31;
    logic [XLEN-1:0]   dec_imm;
    logic              dec_err;

    // Decode happens before storage so only the immediate is registered.
    assign s31 = instr[31];

    always_comb begin
        dec_imm = '0;
        dec_err = 1'b0;
        unique case (1'b1)
            (imm_src == 3'b000):
                dec_imm = {{(XLEN-12){s31}}, instr[31:20]};
            (imm_src == 3'b001):
                dec_imm = {{(XLEN-12){s31}}, instr[31:25], instr[11:7]};
            (imm_src == 3'b010):
                dec_imm = {{(XLEN-12){s31}}, instr[7], instr[30:25],
                           instr[11:8], 1'b0};
            (imm_src == 3'b011):
                dec_imm = {{(XLEN-31){s31}}, instr[30:12], 12'b0};
            (imm_src == 3'b100):
                dec_imm = {{(XLEN-20){s31}}, instr[19:12], instr[20],
                           instr[30:21], 1'b0};
            default:
                dec_err = 1'b1;
        endcase
    end

    assign main_valid = (state_q != S_EMPTY);
    assign skid_valid = (state_q == S_TWO);
    assign in_ready   = !skid_valid;
    assign out_valid  = main_valid;
    assign accept     = in_valid & in_ready;
    assign pop        = main_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        main_imm_d = main_imm_q;
        main_err_d = main_err_q;
        main_tag_d = main_tag_q;
        skid_imm_d = skid_imm_q;
        skid_err_d = skid_err_q;
        skid_tag_d = skid_tag_q;
        unique case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d    = S_ONE;
                    main_imm_d = dec_imm;
                    main_err_d = dec_err;
                    main_tag_d = in_tag;
                end
            end
            S_ONE: begin
                if (accept && pop) begin
                    main_imm_d = dec_imm;
                    main_err_d = dec_err;
                    main_tag_d = in_tag;
                end else if (accept) begin
                    state_d    = S_TWO;
                    skid_imm_d = dec_imm;
                    skid_err_d = dec_err;
                    skid_tag_d = in_tag;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (pop) begin
                    state_d    = S_ONE;
                    main_imm_d = skid_imm_q;
                    main_err_d = skid_err_q;
                    main_tag_d = skid_tag_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        // Flush only invalidates; stale data in the regs is never exposed.
        if (flush) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_EMPTY;
            main_imm_q <= '0;
            main_err_q <= 1'b0;
            main_tag_q <= '0;
            skid_imm_q <= '0;
            skid_err_q <= 1'b0;
            skid_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            main_imm_q <= main_imm_d;
            main_err_q <= main_err_d;
            main_tag_q <= main_tag_d;
            skid_imm_q <= skid_imm_d;
            skid_err_q <= skid_err_d;
            skid_tag_q <= skid_tag_d;
        end
    end

    assign imm_ext = main_imm_q;
    assign imm_err = main_err_q;
    assign out_tag = main_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed + random checks of imm_gen_pipe (XLEN 32 and 64)
// against a queue-based reference of the handshake and immediate formats.
module tb_imm_gen_pipe;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] word;
    logic [2:0]  imm_src;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, imm_err_a;
    logic [31:0] imm_ext_a;
    logic [7:0]  out_tag_a;
    logic        in_ready_b, out_valid_b, imm_err_b;
    logic [63:0] imm_ext_b;
    logic [7:0]  out_tag_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] imm;
        logic        err;
        logic [7:0]  tag;
    } ent_t;

    ent_t q[$];

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .instr(word[31:7]), .imm_src(imm_src), .in_tag(in_tag),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .imm_ext(imm_ext_a), .imm_err(imm_err_a), .out_tag(out_tag_a)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .instr(word[31:7]), .imm_src(imm_src), .in_tag(in_tag),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .imm_ext(imm_ext_b), .imm_err(imm_err_b), .out_tag(out_tag_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference immediate built from field arithmetic on a 32-bit word.
    function automatic ent_t ref_imm(input logic [31:0] w,
                                     input logic [2:0] s,
                                     input logic [7:0] t);
        ent_t e;
        logic signed [31:0] sw;
        logic [31:0] a20, a25, a31, r;
        sw  = signed'(w);
        a20 = sw >>> 20;
        a25 = sw >>> 25;
        a31 = sw >>> 31;
        r   = '0;
        case (s)
            3'd0: r = a20;
            3'd1: r = (a25 << 5) | 32'(w[11:7]);
            3'd2: r = (a31 << 12) | (32'(w[7]) << 11)
                      | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
            3'd3: r = w & 32'hFFFF_F000;
            3'd4: r = (a31 << 20) | (32'(w[19:12]) << 12)
                      | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
            default: r = '0;
        endcase
        e.imm = {{32{r[31]}}, r};
        e.err = (s > 3'd4);
        e.tag = t;
        return e;
    endfunction

    task automatic check_outputs();
        chk("out_valid32", 64'(out_valid_a), 64'(q.size() > 0));
        chk("out_valid64", 64'(out_valid_b), 64'(q.size() > 0));
        chk("in_ready32", 64'(in_ready_a), 64'(q.size() < 2));
        chk("in_ready64", 64'(in_ready_b), 64'(q.size() < 2));
        if (q.size() > 0) begin
            chk("imm32", 64'(imm_ext_a), 64'(q[0].imm[31:0]));
            chk("imm64", imm_ext_b, q[0].imm);
            chk("err32", 64'(imm_err_a), 64'(q[0].err));
            chk("err64", 64'(imm_err_b), 64'(q[0].err));
            chk("tag32", 64'(out_tag_a), 64'(q[0].tag));
            chk("tag64", 64'(out_tag_b), 64'(q[0].tag));
        end
    endtask

    // Called at a negedge; leaves the bench at the following negedge.
    task automatic step(input logic v, input logic [31:0] w,
                        input logic [2:0] s, input logic [7:0] t,
                        input logic rdy, input logic fl);
        logic acc, pp;
        check_outputs();
        in_valid  = v;
        word      = w;
        imm_src   = s;
        in_tag    = t;
        out_ready = rdy;
        flush     = fl;
        acc = v && (q.size() < 2);
        pp  = rdy && (q.size() > 0);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(ref_imm(w, s, t));
        end
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic send1(input logic [31:0] w, input logic [2:0] s,
                         input string nm, input logic [63:0] e64);
        step(1'b1, w, s, 8'h11, 1'b1, 1'b0);
        chk({nm, "_v"}, 64'(out_valid_a), 64'd1);
        chk({nm, "_32"}, 64'(imm_ext_a), 64'(e64[31:0]));
        chk({nm, "_64"}, imm_ext_b, e64);
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_ov"}, 64'(out_valid_a), 64'd0);
        chk({nm, "_ir"}, 64'(in_ready_a), 64'd1);
        chk({nm, "_ov64"}, 64'(out_valid_b), 64'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        word      = '0;
        imm_src   = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle("rst");
        chk("rst_imm32", 64'(imm_ext_a), 64'd0);
        chk("rst_imm64", imm_ext_b, 64'd0);
        chk("rst_err", 64'(imm_err_a), 64'd0);
        chk("rst_tag", 64'(out_tag_a), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        send1(32'hFFF0_0093, 3'd0, "fmtI", 64'hFFFF_FFFF_FFFF_FFFF);
        send1(32'hFE51_2E23, 3'd1, "fmtS", 64'hFFFF_FFFF_FFFF_FFFC);
        send1(32'hFE00_0CE3, 3'd2, "fmtB", 64'hFFFF_FFFF_FFFF_FFF8);
        send1(32'h1234_50B7, 3'd3, "fmtU", 64'h0000_0000_1234_5000);
        send1(32'h0010_00EF, 3'd4, "fmtJ", 64'h0000_0000_0000_0800);
        send1(32'h8000_0037, 3'd3, "x64U", 64'hFFFF_FFFF_8000_0000);
        send1(32'h7FF0_0093, 3'd0, "x64I", 64'h0000_0000_0000_07FF);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 16; i++) begin
            step(1'b1, $urandom, 3'($urandom_range(0, 4)), 8'(i),
                 1'b1, 1'b0);
            chk("strm_ir", 64'(in_ready_a), 64'd1);
            chk("strm_tag", 64'(out_tag_a), 64'(i));
        end
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            step(1'b1, $urandom, 3'd0, 8'(8'h40 + i), 1'b0, 1'b0);
        end
        chk("stall_ir", 64'(in_ready_a), 64'd0);
        chk("stall_tag", 64'(out_tag_a), 64'h40);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        end
        check_idle("drain");

        step(1'b1, 32'hFFFF_FFFF, 3'b110, 8'h5A, 1'b1, 1'b0);
        chk("ill_imm", 64'(imm_ext_a), 64'd0);
        chk("ill_err", 64'(imm_err_a), 64'd1);
        chk("ill_tag", 64'(out_tag_a), 64'h5A);
        step(1'b1, 32'hFFF0_0093, 3'd0, 8'h5B, 1'b1, 1'b0);
        chk("legal_err", 64'(imm_err_a), 64'd0);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);

        step(1'b1, $urandom, 3'd1, 8'h71, 1'b0, 1'b0);
        step(1'b1, $urandom, 3'd2, 8'h72, 1'b0, 1'b0);
        chk("two_ir", 64'(in_ready_a), 64'd0);
        step(1'b1, $urandom, 3'd3, 8'h73, 1'b1, 1'b1);
        check_idle("flush");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        end
        check_idle("flush_post");

        step(1'b1, $urandom, 3'd4, 8'h81, 1'b0, 1'b0);
        step(1'b1, $urandom, 3'd0, 8'h82, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check_idle("arst");
        chk("arst_imm", 64'(imm_ext_a), 64'd0);
        chk("arst_tag", 64'(out_tag_a), 64'd0);
        q.delete();
        #1 reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        end
        check_idle("arst_post");

        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, $urandom, 3'($urandom % 8),
                 8'($urandom), ($urandom % 3) != 0, ($urandom % 32) == 0);
        end
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
